bus_arbiter_split: RTL and testbench

//  Central arbiter/scheduler for the shared serial system bus. Grants one master at a time
//  (round-robin), decodes the target slave from the first serial address bits, steers the

---
 rtl/bus_arbiter_split.sv | 137 +++++++++++++
 tb/tb_bus_arbiter_split.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_split.sv
// bus_arbiter_split: round-robin serial-bus arbiter with slave decode and one parked split transaction
module bus_arbiter_split #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 3,
    parameter int SEL_BITS    = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] m_req,
    output logic [NUM_MASTERS-1:0] m_grant,
    input  logic                   bus_mvalid,
    input  logic                   bus_wr,
    input  logic [NUM_SLAVES-1:0]  s_split,
    output logic [NUM_SLAVES-1:0]  s_sel,
    output logic                   bus_busy,
    output logic                   split_pend,
    output logic                   dec_err
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] GRANT    = 3'd1;
    localparam logic [2:0] DECODE   = 3'd2;
    localparam logic [2:0] ACTIVE   = 3'd3;
    localparam logic [2:0] HOLD_ERR = 3'd4;
    localparam int MW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(SEL_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SEL_BITS - 1);
    localparam logic [SEL_BITS:0] NS = (SEL_BITS + 1)'(NUM_SLAVES);
    localparam logic [NUM_MASTERS-1:0] ONE_M = NUM_MASTERS'(1);
    localparam logic [NUM_SLAVES-1:0] ONE_S = NUM_SLAVES'(1);

    logic [2:0]             state;
    logic [MW-1:0]          gnt_idx, rr_ptr, parked_m, win;
    logic [SEL_BITS-1:0]    sel_idx, parked_s, shift, shift_nxt;
    logic [CW-1:0]          bit_cnt;
    logic [NUM_MASTERS-1:0] elig;
    logic                   win_ok, gnt_req, resume, bits_done, idx_ok;

    always_comb begin
        gnt_req   = m_req[gnt_idx];
        elig      = m_req & ~(split_pend ? ONE_M << parked_m : '0);
        resume    = split_pend && m_req[parked_m] && !s_split[parked_s];
        shift_nxt = (state == GRANT ? '0 : shift << 1) | SEL_BITS'(bus_wr);
        bits_done = state == GRANT ? SEL_BITS == 1 : bit_cnt == CNT_LAST;
        idx_ok    = {1'b0, shift_nxt} < NS;
        win       = '0;
        win_ok    = 1'b0;
        // descending scan so the requester closest to rr_ptr is the last (winning) assignment
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (elig[(int'(rr_ptr) + i) % NUM_MASTERS]) begin
                win    = MW'((int'(rr_ptr) + i) % NUM_MASTERS);
                win_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            m_grant    <= '0;
            s_sel      <= '0;
            bus_busy   <= 1'b0;
            split_pend <= 1'b0;
            dec_err    <= 1'b0;
            gnt_idx    <= '0;
            rr_ptr     <= '0;
            parked_m   <= '0;
            parked_s   <= '0;
            sel_idx    <= '0;
            shift      <= '0;
            bit_cnt    <= '0;
        end else begin
            dec_err <= 1'b0;
            if (split_pend && !m_req[parked_m])
                split_pend <= 1'b0;
            if (state != IDLE && !gnt_req) begin
                m_grant  <= '0;
                s_sel    <= '0;
                bus_busy <= 1'b0;
                state    <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (resume) begin
                            m_grant    <= ONE_M << parked_m;
                            s_sel      <= ONE_S << parked_s;
                            gnt_idx    <= parked_m;
                            sel_idx    <= parked_s;
                            split_pend <= 1'b0;
                            bus_busy   <= 1'b1;
                            state      <= ACTIVE;
                        end else if (win_ok) begin
                            m_grant  <= ONE_M << win;
                            gnt_idx  <= win;
                            rr_ptr   <= win == MW'(NUM_MASTERS - 1) ? '0 : win + MW'(1);
                            bus_busy <= 1'b1;
                            state    <= GRANT;
                        end
                    end
                    GRANT, DECODE: begin
                        if (bus_mvalid) begin
                            shift   <= shift_nxt;
                            bit_cnt <= state == GRANT ? CW'(1) : bit_cnt + CW'(1);
                            if (!bits_done)
                                state <= DECODE;
                            else if (idx_ok) begin
                                s_sel   <= ONE_S << shift_nxt;
                                sel_idx <= shift_nxt;
                                state   <= ACTIVE;
                            end else begin
                                dec_err <= 1'b1;
                                state   <= HOLD_ERR;
                            end
                        end
                    end
                    ACTIVE: begin
                        if (s_split[sel_idx] && !split_pend) begin
                            parked_m   <= gnt_idx;
                            parked_s   <= sel_idx;
                            split_pend <= 1'b1;
                            m_grant    <= '0;
                            s_sel      <= '0;
                            bus_busy   <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    HOLD_ERR: state <= HOLD_ERR;
                    default: begin
                        m_grant  <= '0;
                        s_sel    <= '0;
                        bus_busy <= 1'b0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bus_arbiter_split.sv
// tb_bus_arbiter_split: scenario tasks with a grant/select scoreboard for bus_arbiter_split
module tb_bus_arbiter_split;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] m_req = '0;
    logic [1:0] m_grant;
    logic       bus_mvalid = 1'b0;
    logic       bus_wr = 1'b0;
    logic [2:0] s_split = '0;
    logic [2:0] s_sel;
    logic       bus_busy, split_pend, dec_err;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] grant;
        logic [2:0] sel;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;

    bus_arbiter_split dut (
        .clk(clk), .rstn(rstn), .m_req(m_req), .m_grant(m_grant),
        .bus_mvalid(bus_mvalid), .bus_wr(bus_wr), .s_split(s_split),
        .s_sel(s_sel), .bus_busy(bus_busy), .split_pend(split_pend), .dec_err(dec_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [1:0] idx);
        bus_mvalid = 1'b1;
        bus_wr = idx[1];
        tick();
        bus_wr = idx[0];
        tick();
        bus_mvalid = 1'b0;
        bus_wr = 1'b0;
    endtask

    task automatic apply_reset;
        rstn = 1'b0;
        m_req = '0;
        s_split = '0;
        bus_mvalid = 1'b0;
        bus_wr = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic pop_cmp(input string name);
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            if (m_grant !== e.grant || s_sel !== e.sel) begin
                failures++;
                $display("FAIL %s grant/sel got=%b/%b exp=%b/%b", name, m_grant, s_sel, e.grant, e.sel);
            end
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        tick();
        checks++;
        if ({m_grant, s_sel, bus_busy, split_pend, dec_err} !== 8'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {m_grant, s_sel, bus_busy, split_pend, dec_err});
        end
        apply_reset();
    endtask

    task automatic test_basic;
        apply_reset();
        m_req = 2'b01;
        exp_q.push_back('{2'b01, 3'b010});
        tick();
        checks++;
        if (m_grant !== 2'b01 || bus_busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_grant got=%b/%b exp=01/1", m_grant, bus_busy);
        end
        send_bits(2'd1);
        pop_cmp("basic_active");
        m_req = 2'b00;
        tick();
        checks++;
        if ({m_grant, s_sel, bus_busy} !== 6'b0) begin
            failures++;
            $display("FAIL basic_release got=%b exp=0", {m_grant, s_sel, bus_busy});
        end
    endtask

    task automatic test_round_robin;
        apply_reset();
        m_req = 2'b11;
        exp_q.push_back('{2'b01, 3'b001});
        tick();
        send_bits(2'd0);
        pop_cmp("rr_first_m0");
        m_req = 2'b10;
        tick();
        checks++;
        if (m_grant !== 2'b00) begin
            failures++;
            $display("FAIL rr_idle_gap got=%b exp=00", m_grant);
        end
        exp_q.push_back('{2'b10, 3'b010});
        tick();
        send_bits(2'd1);
        pop_cmp("rr_second_m1");
        m_req = 2'b01;
        tick();
        tick();
        checks++;
        if (m_grant !== 2'b01) begin
            failures++;
            $display("FAIL rr_third_m0 got=%b exp=01", m_grant);
        end
        m_req = 2'b00;
        tick();
    endtask

    task automatic test_split;
        apply_reset();
        m_req = 2'b01;
        exp_q.push_back('{2'b01, 3'b100});
        tick();
        send_bits(2'd2);
        pop_cmp("split_m0_active");
        m_req = 2'b11;
        s_split = 3'b100;
        tick();
        checks++;
        if ({m_grant, s_sel, split_pend} !== 6'b000001) begin
            failures++;
            $display("FAIL split_park got=%b exp=000001", {m_grant, s_sel, split_pend});
        end
        tick();
        checks++;
        if (m_grant !== 2'b10) begin
            failures++;
            $display("FAIL split_m1_grant got=%b exp=10", m_grant);
        end
        s_split = 3'b000;
        exp_q.push_back('{2'b10, 3'b001});
        send_bits(2'd0);
        pop_cmp("split_m1_active");
        checks++;
        if (split_pend !== 1'b1) begin
            failures++;
            $display("FAIL split_wait_busy got=%b exp=1", split_pend);
        end
        m_req = 2'b01;
        tick();
        checks++;
        if ({m_grant, s_sel, split_pend} !== 6'b000001) begin
            failures++;
            $display("FAIL split_m1_release got=%b exp=000001", {m_grant, s_sel, split_pend});
        end
        exp_q.push_back('{2'b01, 3'b100});
        tick();
        pop_cmp("split_resume");
        checks++;
        if (split_pend !== 1'b0 || bus_busy !== 1'b1) begin
            failures++;
            $display("FAIL split_resume_flags got=%b/%b exp=0/1", split_pend, bus_busy);
        end
        s_split = 3'b100;
        m_req = 2'b00;
        tick();
        checks++;
        if ({m_grant, s_sel, split_pend} !== 6'b0) begin
            failures++;
            $display("FAIL split_drop_wins got=%b exp=0", {m_grant, s_sel, split_pend});
        end
        s_split = 3'b000;
    endtask

    task automatic test_dec_err;
        apply_reset();
        m_req = 2'b01;
        tick();
        exp_q.push_back('{2'b01, 3'b000});
        send_bits(2'd3);
        pop_cmp("decerr_hold");
        checks++;
        if (dec_err !== 1'b1) begin
            failures++;
            $display("FAIL decerr_pulse got=%b exp=1", dec_err);
        end
        tick();
        checks++;
        if (dec_err !== 1'b0 || m_grant !== 2'b01 || bus_busy !== 1'b1) begin
            failures++;
            $display("FAIL decerr_single got=%b/%b/%b exp=0/01/1", dec_err, m_grant, bus_busy);
        end
        m_req = 2'b00;
        tick();
        checks++;
        if (m_grant !== 2'b00 || bus_busy !== 1'b0) begin
            failures++;
            $display("FAIL decerr_release got=%b/%b exp=00/0", m_grant, bus_busy);
        end
    endtask

    task automatic test_gaps;
        apply_reset();
        m_req = 2'b01;
        exp_q.push_back('{2'b01, 3'b100});
        tick();
        tick();
        tick();
        bus_mvalid = 1'b1;
        bus_wr = 1'b1;
        tick();
        bus_mvalid = 1'b0;
        bus_wr = 1'b0;
        tick();
        tick();
        checks++;
        if (s_sel !== 3'b000) begin
            failures++;
            $display("FAIL gaps_mid got=%b exp=000", s_sel);
        end
        bus_mvalid = 1'b1;
        tick();
        bus_mvalid = 1'b0;
        pop_cmp("gaps_active");
        m_req = 2'b00;
        tick();
        m_req = 2'b10;
        tick();
        checks++;
        if (m_grant !== 2'b10) begin
            failures++;
            $display("FAIL grant_drop_pre got=%b exp=10", m_grant);
        end
        m_req = 2'b00;
        tick();
        checks++;
        if (m_grant !== 2'b00 || bus_busy !== 1'b0) begin
            failures++;
            $display("FAIL grant_drop got=%b/%b exp=00/0", m_grant, bus_busy);
        end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        m_req = 2'b01;
        tick();
        send_bits(2'd1);
        m_req = 2'b11;
        s_split = 3'b010;
        tick();
        tick();
        send_bits(2'd0);
        checks++;
        if (split_pend !== 1'b1 || s_sel !== 3'b001) begin
            failures++;
            $display("FAIL rstmid_setup got=%b/%b exp=1/001", split_pend, s_sel);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({m_grant, s_sel, bus_busy, split_pend, dec_err} !== 8'b0) begin
            failures++;
            $display("FAIL rstmid_async got=%b exp=0", {m_grant, s_sel, bus_busy, split_pend, dec_err});
        end
        s_split = 3'b000;
        #1 rstn = 1'b1;
        tick();
        checks++;
        if (m_grant !== 2'b01 || s_sel !== 3'b000 || split_pend !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_parked_cleared got=%b/%b/%b exp=01/000/0", m_grant, s_sel, split_pend);
        end
        m_req = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_split();
        test_dec_err();
        test_gaps();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
